// File: rtl/map_pkg.sv
// Shared map constants, cell codes and the read-tag type used by the grid
// read path.
package map_pkg;

    // Grid dimensions in cells
    localparam int MAP_W = 40;
    localparam int MAP_H = 30;

    // Coordinate and cell-code widths
    localparam int X_W    = 6;
    localparam int Y_W    = 5;
    localparam int CELL_W = 3;

    // Cell codes held in the grid memory
    localparam logic [CELL_W-1:0] CELL_EMPTY = 3'd0;
    localparam logic [CELL_W-1:0] CELL_WALL  = 3'd1;
    localparam logic [CELL_W-1:0] CELL_DOOR  = 3'd2;
    localparam logic [CELL_W-1:0] CELL_EXIT  = 3'd3;

    // Which requester a lookup belongs to
    typedef enum logic {
        OWNER_P = 1'b0,
        OWNER_R = 1'b1
    } owner_e;

    // Travels alongside each lookup until its data comes back
    typedef struct packed {
        logic   live;
        owner_e owner;
        logic   oob;
    } read_tag_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Fixed-depth shift register carrying lookup tags in step with the grid
// memory read pipeline. Clearing drops every in-flight tag.
module read_tag_pipe
    import map_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  read_tag_t i_tag,
    output read_tag_t o_tag
);

    read_tag_t r_stage [DEPTH];

    // Shift tags one stage per cycle; reset empties the whole pipe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/grid_read_arbiter.sv
// Round-robin arbiter sharing the grid memory read port between the player
// updater and the raycaster. One lookup per cycle, fully pipelined, results
// routed back to the issuing requester in grant order.
module grid_read_arbiter #(
    parameter int                               MAP_W        = map_pkg::MAP_W,
    parameter int                               MAP_H        = map_pkg::MAP_H,
    parameter int                               READ_LATENCY = 1,
    parameter logic [map_pkg::CELL_W-1:0]       OOB_CELL     = map_pkg::CELL_WALL
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           p_req,
    input  logic [map_pkg::X_W-1:0]        p_x,
    input  logic [map_pkg::Y_W-1:0]        p_y,
    output logic                           p_gnt,
    output logic                           p_valid,
    output logic [map_pkg::CELL_W-1:0]     p_data,
    input  logic                           r_req,
    input  logic [map_pkg::X_W-1:0]        r_x,
    input  logic [map_pkg::Y_W-1:0]        r_y,
    output logic                           r_gnt,
    output logic                           r_valid,
    output logic [map_pkg::CELL_W-1:0]     r_data,
    output logic [map_pkg::X_W-1:0]        grid_x,
    output logic [map_pkg::Y_W-1:0]        grid_y,
    input  logic [map_pkg::CELL_W-1:0]     grid_out
);

    import map_pkg::*;

    // One stage for the address register plus READ_LATENCY memory stages
    localparam int TAG_DEPTH = READ_LATENCY + 1;

    logic              w_p_gnt;
    logic              w_r_gnt;
    logic              w_any_gnt;
    logic [X_W-1:0]    w_sel_x;
    logic [Y_W-1:0]    w_sel_y;
    logic              w_oob;
    read_tag_t         w_tag_in;
    read_tag_t         w_tail;
    logic [CELL_W-1:0] w_cell;

    logic              r_last_p;     // 1: most recent grant went to the raycaster
    logic [X_W-1:0]    r_grid_x;
    logic [Y_W-1:0]    r_grid_y;
    logic              r_p_valid;
    logic              r_r_valid;
    logic [CELL_W-1:0] r_p_data;
    logic [CELL_W-1:0] r_r_data;

    // Round-robin grant: contention goes to whoever was not served last;
    // nothing is granted while reset is held
    always_comb begin
        w_p_gnt = 1'b0;
        w_r_gnt = 1'b0;
        if (reset) begin
            if (p_req && r_req) begin
                if (r_last_p) begin
                    w_p_gnt = 1'b1;
                end else begin
                    w_r_gnt = 1'b1;
                end
            end else if (p_req) begin
                w_p_gnt = 1'b1;
            end else if (r_req) begin
                w_r_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_p_gnt | w_r_gnt;
    assign w_sel_x   = w_r_gnt ? r_x : p_x;
    assign w_sel_y   = w_r_gnt ? r_y : p_y;
    // Out-of-range lookups still use the memory slot so ordering is unchanged
    assign w_oob     = (w_sel_x >= X_W'(MAP_W)) || (w_sel_y >= Y_W'(MAP_H));

    assign w_tag_in.live  = w_any_gnt;
    assign w_tag_in.owner = w_r_gnt ? OWNER_R : OWNER_P;
    assign w_tag_in.oob   = w_any_gnt & w_oob;

    // Remember who was served last and register the granted address
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_p <= 1'b1;
            r_grid_x <= '0;
            r_grid_y <= '0;
        end else if (w_any_gnt) begin
            r_last_p <= w_r_gnt;
            r_grid_x <= w_sel_x;
            r_grid_y <= w_sel_y;
        end
    end

    read_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clock (clock),
        .reset (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tail)
    );

    assign w_cell = w_tail.oob ? OOB_CELL : grid_out;

    // Return stage: steer the memory data to the owning requester and pulse its valid
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_p_valid <= 1'b0;
            r_r_valid <= 1'b0;
            r_p_data  <= '0;
            r_r_data  <= '0;
        end else begin
            r_p_valid <= w_tail.live && (w_tail.owner == OWNER_P);
            r_r_valid <= w_tail.live && (w_tail.owner == OWNER_R);
            if (w_tail.live) begin
                if (w_tail.owner == OWNER_P) begin
                    r_p_data <= w_cell;
                end else begin
                    r_r_data <= w_cell;
                end
            end
        end
    end

    assign p_gnt   = w_p_gnt;
    assign r_gnt   = w_r_gnt;
    assign grid_x  = r_grid_x;
    assign grid_y  = r_grid_y;
    assign p_valid = r_p_valid;
    assign r_valid = r_r_valid;
    assign p_data  = r_p_data;
    assign r_data  = r_r_data;

endmodule

// File: tb/tb_grid_read_arbiter.sv
// Scoreboard bench for grid_read_arbiter: a latency-1 instance exercised with
// directed vectors, plus a latency-3 instance for the single-lookup timing.
module tb_grid_read_arbiter;

    import map_pkg::*;

    typedef struct {
        bit         owner;   // 0 player, 1 raycaster
        logic [2:0] data;
        int         due;     // cycle in which the valid pulse must appear
    } exp_t;

    typedef struct {
        bit         pq;
        logic [5:0] px;
        logic [4:0] py;
        bit         rq;
        logic [5:0] rx;
        logic [4:0] ry;
        bit         ep;
        bit         er;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- latency-1 instance ----------------
    logic       p_req = 1'b0, r_req = 1'b0;
    logic [5:0] p_x = '0, r_x = '0;
    logic [4:0] p_y = '0, r_y = '0;
    logic       p_gnt, r_gnt, p_valid, r_valid;
    logic [2:0] p_data, r_data, grid_out;
    logic [5:0] grid_x;
    logic [4:0] grid_y;

    grid_read_arbiter #(.READ_LATENCY(1)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .p_req    (p_req),
        .p_x      (p_x),
        .p_y      (p_y),
        .p_gnt    (p_gnt),
        .p_valid  (p_valid),
        .p_data   (p_data),
        .r_req    (r_req),
        .r_x      (r_x),
        .r_y      (r_y),
        .r_gnt    (r_gnt),
        .r_valid  (r_valid),
        .r_data   (r_data),
        .grid_x   (grid_x),
        .grid_y   (grid_y),
        .grid_out (grid_out)
    );

    // ---------------- latency-3 instance ----------------
    logic       p3_req = 1'b0;
    logic [5:0] p3_x = '0;
    logic [4:0] p3_y = '0;
    logic       r3_req = 1'b0;
    logic [5:0] r3_x = '0;
    logic [4:0] r3_y = '0;
    logic       p3_gnt, r3_gnt, p3_valid, r3_valid;
    logic [2:0] p3_data, r3_data, grid3_out;
    logic [5:0] grid3_x;
    logic [4:0] grid3_y;
    logic [2:0] m3_s1, m3_s2;

    grid_read_arbiter #(.READ_LATENCY(3)) u_dut3 (
        .clock    (clock),
        .reset    (reset),
        .p_req    (p3_req),
        .p_x      (p3_x),
        .p_y      (p3_y),
        .p_gnt    (p3_gnt),
        .p_valid  (p3_valid),
        .p_data   (p3_data),
        .r_req    (r3_req),
        .r_x      (r3_x),
        .r_y      (r3_y),
        .r_gnt    (r3_gnt),
        .r_valid  (r3_valid),
        .r_data   (r3_data),
        .grid_x   (grid3_x),
        .grid_y   (grid3_y),
        .grid_out (grid3_out)
    );

    // Grid contents: a simple closed form so expected data is easy to derive
    function automatic logic [2:0] cell_of(input logic [5:0] x, input logic [4:0] y);
        int v;
        v = int'(x) + 3 * int'(y);
        return 3'(v & 7);
    endfunction

    function automatic logic [2:0] expect_cell(input logic [5:0] x, input logic [4:0] y);
        if (x >= 6'd40 || y >= 5'd30) return 3'd1;
        return cell_of(x, y);
    endfunction

    // Grid memory models with 1 and 3 cycles of read latency
    always @(posedge clock) begin
        grid_out  <= cell_of(grid_x, grid_y);
        m3_s1     <= cell_of(grid3_x, grid3_y);
        m3_s2     <= m3_s1;
        grid3_out <= m3_s2;
    end

    exp_t q1[$];
    exp_t q3[$];
    exp_t mon_e;
    exp_t mon3_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the latency-1 instance: every valid pops the oldest expectation
    always @(negedge clock) begin
        if (reset) begin
            if (p_valid && r_valid) begin
                chk("both_valid", 32'd1, 32'd0);
            end else if (p_valid || r_valid) begin
                if (q1.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = q1.pop_front();
                    chk("result_owner", {31'd0, r_valid}, {31'd0, mon_e.owner});
                    chk("result_data", {29'd0, r_valid ? r_data : p_data}, {29'd0, mon_e.data});
                    chk("result_cycle", cyc, mon_e.due);
                    $display("[TB] result %s data=%0d cycle=%0d", r_valid ? "R" : "P",
                             r_valid ? r_data : p_data, cyc);
                end
            end
        end
    end

    // Monitor for the latency-3 instance
    always @(negedge clock) begin
        if (reset && (p3_valid || r3_valid)) begin
            if (q3.size() == 0 || r3_valid) begin
                chk("lat3_spurious_valid", 32'd1, 32'd0);
            end else begin
                mon3_e = q3.pop_front();
                chk("lat3_data", {29'd0, p3_data}, {29'd0, mon3_e.data});
                chk("lat3_cycle", cyc, mon3_e.due);
                $display("[TB] lat3 result P data=%0d cycle=%0d", p3_data, cyc);
            end
        end
    end

    // Drive one cycle of requests, check grants, and queue the expected results
    task automatic step(input vec_t v);
        @(posedge clock);
        #1;
        p_req = v.pq; p_x = v.px; p_y = v.py;
        r_req = v.rq; r_x = v.rx; r_y = v.ry;
        @(negedge clock);
        chk("p_gnt", {31'd0, p_gnt}, {31'd0, v.ep});
        chk("r_gnt", {31'd0, r_gnt}, {31'd0, v.er});
        if (v.ep) q1.push_back('{1'b0, expect_cell(v.px, v.py), cyc + 3});
        if (v.er) q1.push_back('{1'b1, expect_cell(v.rx, v.ry), cyc + 3});
        $display("[TB] cycle %0d req P=%0d(%0d,%0d) R=%0d(%0d,%0d) gnt P=%0d R=%0d",
                 cyc, v.pq, v.px, v.py, v.rq, v.rx, v.ry, p_gnt, r_gnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('{0, 6'd0, 5'd0, 0, 6'd0, 5'd0, 0, 0});
    endtask

    vec_t ray_vecs[4];
    vec_t cont_vecs[6];

    initial begin
        ray_vecs[0] = '{0, 6'd0, 5'd0, 1, 6'd0,  5'd0,  0, 1};
        ray_vecs[1] = '{0, 6'd0, 5'd0, 1, 6'd39, 5'd29, 0, 1};
        ray_vecs[2] = '{0, 6'd0, 5'd0, 1, 6'd40, 5'd0,  0, 1};
        ray_vecs[3] = '{0, 6'd0, 5'd0, 1, 6'd0,  5'd30, 0, 1};

        // Raycaster holds its address until served; player changes after each grant
        cont_vecs[0] = '{1, 6'd1, 5'd2, 1, 6'd10, 5'd3, 1, 0};
        cont_vecs[1] = '{1, 6'd4, 5'd5, 1, 6'd10, 5'd3, 0, 1};
        cont_vecs[2] = '{1, 6'd4, 5'd5, 1, 6'd11, 5'd4, 1, 0};
        cont_vecs[3] = '{1, 6'd6, 5'd7, 1, 6'd11, 5'd4, 0, 1};
        cont_vecs[4] = '{1, 6'd6, 5'd7, 1, 6'd12, 5'd5, 1, 0};
        cont_vecs[5] = '{1, 6'd8, 5'd9, 1, 6'd12, 5'd5, 0, 1};

        // Reset state, with both requests raised to confirm grants stay low
        reset = 1'b0;
        p_req = 1'b1; r_req = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_p_gnt", {31'd0, p_gnt}, 32'd0);
        chk("rst_r_gnt", {31'd0, r_gnt}, 32'd0);
        chk("rst_grid_x", {26'd0, grid_x}, 32'd0);
        chk("rst_grid_y", {27'd0, grid_y}, 32'd0);
        chk("rst_valids", {30'd0, p_valid, r_valid}, 32'd0);
        chk("rst_data", {26'd0, p_data, r_data}, 32'd0);
        p_req = 1'b0; r_req = 1'b0;
        reset = 1'b1;

        // Single player lookup at (5,7)
        step('{1, 6'd5, 5'd7, 0, 6'd0, 5'd0, 1, 0});
        idle(1);
        chk("addr_x_after_grant", {26'd0, grid_x}, 32'd5);
        chk("addr_y_after_grant", {27'd0, grid_y}, 32'd7);
        idle(3);

        // Raycaster back-to-back including two out-of-bounds lookups
        for (int i = 0; i < 4; i++) step(ray_vecs[i]);
        idle(5);
        chk("hold_grid_x", {26'd0, grid_x}, 32'd0);
        chk("hold_grid_y", {27'd0, grid_y}, 32'd30);
        chk("hold_r_data", {29'd0, r_data}, 32'd1);
        chk("hold_p_data", {29'd0, p_data}, 32'd2);

        // Two lookups in flight, then asynchronous reset mid-cycle
        step('{1, 6'd1, 5'd1, 1, 6'd2, 5'd2, 1, 0});
        step('{0, 6'd1, 5'd1, 1, 6'd2, 5'd2, 0, 1});
        @(posedge clock);
        #3;
        q1.delete();
        reset = 1'b0;
        #1;
        chk("async_rst_r_gnt", {31'd0, r_gnt}, 32'd0);
        chk("async_rst_grid", {21'd0, grid_x, grid_y}, 32'd0);
        chk("async_rst_valids", {30'd0, p_valid, r_valid}, 32'd0);
        chk("async_rst_data", {26'd0, p_data, r_data}, 32'd0);
        p_req = 1'b0; r_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(2);

        // Continuous contention straight out of reset: P,R,P,R,P,R
        for (int i = 0; i < 6; i++) step(cont_vecs[i]);
        idle(5);

        // Latency-3 build: single grant, result five cycles later
        @(posedge clock);
        #1;
        p3_req = 1'b1; p3_x = 6'd5; p3_y = 5'd7;
        @(negedge clock);
        chk("lat3_p_gnt", {31'd0, p3_gnt}, 32'd1);
        if (p3_gnt) q3.push_back('{1'b0, 3'd2, cyc + 5});
        @(posedge clock);
        #1;
        p3_req = 1'b0;
        repeat (8) @(negedge clock);

        // Anything still queued was never returned
        chk("lost_results", q1.size(), 32'd0);
        chk("lat3_lost_results", q3.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
